// File: rtl/stack_cpu_ext_pkg.sv
// Shared types and defaults for the extended stack CPU: opcodes, FSM states,
// error codes and the per-opcode operand table used by the decoder.
package stack_cpu_ext_defs;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_STACK_DEPTH  = 16;
    localparam int DEF_INSTR_WIDTH  = 16;
    localparam int DEF_PC_WIDTH     = 10;
    localparam int DEF_SSTEP_ENABLE = 0;
    localparam int OPC_WIDTH        = 5;
    localparam int IMM_WIDTH        = 10;

    typedef enum logic [4:0] {
        OP_PUSHI  = 5'd0,
        OP_ADD    = 5'd1,
        OP_SUB    = 5'd2,
        OP_MUL    = 5'd3,
        OP_DIV    = 5'd4,
        OP_MOD    = 5'd5,
        OP_AND    = 5'd6,
        OP_OR     = 5'd7,
        OP_INVERT = 5'd8,
        OP_DUP    = 5'd9,
        OP_DROP   = 5'd10,
        OP_SWAP   = 5'd11,
        OP_JMP    = 5'd12,
        OP_JZ     = 5'd13,
        OP_NOP    = 5'd14,
        OP_HALT   = 5'd31
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_HALTED = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_UNDERFLOW = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_DIV_ZERO  = 2'd2,
        ERR_ILLEGAL   = 2'd3
    } err_code_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] pops;
        logic [1:0] pushes;
    } op_info_t;

    function automatic op_info_t op_info(input logic [OPC_WIDTH-1:0] opc);
        op_info_t info;
        case (opc)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV,
            OP_MOD, OP_AND, OP_OR:         info = '{1'b1, 2'd2, 2'd1};
            OP_INVERT:                     info = '{1'b1, 2'd1, 2'd1};
            OP_DUP:                        info = '{1'b1, 2'd1, 2'd2};
            OP_SWAP:                       info = '{1'b1, 2'd2, 2'd2};
            OP_DROP, OP_JZ:                info = '{1'b1, 2'd1, 2'd0};
            OP_PUSHI:                      info = '{1'b1, 2'd0, 2'd1};
            OP_JMP, OP_NOP, OP_HALT:       info = '{1'b1, 2'd0, 2'd0};
            default:                       info = '{1'b0, 2'd0, 2'd0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/stack_cpu_ext_if.sv
// Instruction fetch bus between the CPU (master) and program memory (slave).
interface stack_cpu_ext_if
    import stack_cpu_ext_defs::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
);
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instruction;

    modport master (output pc, input instruction);
    modport slave  (input pc, output instruction);
endinterface

// File: rtl/stack_cpu_ext_lifo_regfile.sv
// LIFO register file: combinational TOS/NOS reads, one write port that pops
// 0-2 entries and pushes 0-2 entries in the same cycle (push_hi lands on top).
module lifo_regfile #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 16,
    parameter int DEPTH_WIDTH = $clog2(STACK_DEPTH + 1)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [1:0]             pop_cnt,
    input  logic [1:0]             push_cnt,
    input  logic [DATA_WIDTH-1:0]  push_lo,
    input  logic [DATA_WIDTH-1:0]  push_hi,
    output logic [DATA_WIDTH-1:0]  tos,
    output logic [DATA_WIDTH-1:0]  nos,
    output logic [DEPTH_WIDTH-1:0] depth
);
    localparam int DW = DEPTH_WIDTH;
    localparam int AW = $clog2(STACK_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [STACK_DEPTH];
    logic [DW-1:0]         depth_r;
    logic [DW-1:0]         base_s;

    // Read top two entries; absent entries read as zero.
    always_comb begin
        tos    = '0;
        nos    = '0;
        base_s = depth_r - DW'(pop_cnt);
        if (depth_r != '0) begin
            tos = mem_r[AW'(depth_r - DW'(1))];
        end else begin
            tos = '0;
        end
        if (depth_r >= DW'(2)) begin
            nos = mem_r[AW'(depth_r - DW'(2))];
        end else begin
            nos = '0;
        end
    end

    // Commit pops and pushes; the caller guarantees no under/overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_r <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (push_cnt != 2'd0 && base_s == DW'(i)) begin
                    mem_r[i] <= push_lo;
                end else if (push_cnt == 2'd2 && (base_s + DW'(1)) == DW'(i)) begin
                    mem_r[i] <= push_hi;
                end
            end
            depth_r <= base_s + DW'(push_cnt);
        end
    end

    assign depth = depth_r;

endmodule

// File: rtl/stack_cpu_ext.sv
// Multi-cycle stack CPU: FETCH/DECODE/EXEC/WB per instruction, decode-time
// fault detection into a sticky ERROR state, optional single-step pause.
module stack_cpu_ext
    import stack_cpu_ext_defs::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
    parameter int INSTR_WIDTH  = DEF_INSTR_WIDTH,
    parameter int PC_WIDTH     = DEF_PC_WIDTH,
    parameter int SSTEP_ENABLE = DEF_SSTEP_ENABLE
)(
    input  logic                                 clk,
    input  logic                                 reset,
    stack_cpu_ext_if.master                      bus,
    input  logic                                 single_step,
    output logic signed [DATA_WIDTH-1:0]         result,
    output logic                                 valid_result,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
    output logic                                 error,
    output logic [1:0]                           err_code,
    output logic                                 halt
);
    localparam int DW  = $clog2(STACK_DEPTH + 1);
    localparam int DW1 = DW + 1;

    state_t                        state_r, next_state_s;
    logic [INSTR_WIDTH-1:0]        ir_r;
    logic [PC_WIDTH-1:0]           pc_r;
    logic signed [DATA_WIDTH-1:0]  result_r, push_lo_r, push_hi_r;
    logic                          valid_r, error_r, halt_r, step_prev_r;
    err_code_t                     err_code_r;

    logic [OPC_WIDTH-1:0]          opc_s;
    logic [IMM_WIDTH-1:0]          imm_s;
    op_info_t                      info_s;
    logic signed [DATA_WIDTH-1:0]  tos_s, nos_s, imm_ext_s, alu_s;
    logic signed [DATA_WIDTH-1:0]  push_lo_s, push_hi_s, new_tos_s;
    logic [DW-1:0]                 depth_s;
    logic [DW1-1:0]                depth_after_s;
    logic                          fault_s, step_edge_s, wb_s, unused_s;
    err_code_t                     fault_code_s;

    assign opc_s       = ir_r[INSTR_WIDTH-1 -: OPC_WIDTH];
    assign imm_s       = ir_r[IMM_WIDTH-1:0];
    assign unused_s    = ^ir_r[INSTR_WIDTH-OPC_WIDTH-1:IMM_WIDTH];
    assign info_s      = op_info(opc_s);
    assign imm_ext_s   = {{(DATA_WIDTH-IMM_WIDTH){imm_s[IMM_WIDTH-1]}}, imm_s};
    assign step_edge_s = (SSTEP_ENABLE != 0) && single_step && !step_prev_r;

    lifo_regfile #(
        .DATA_WIDTH  (DATA_WIDTH),
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_WIDTH (DW)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_s),
        .pop_cnt  (info_s.pops),
        .push_cnt (info_s.pushes),
        .push_lo  (push_lo_r),
        .push_hi  (push_hi_r),
        .tos      (tos_s),
        .nos      (nos_s),
        .depth    (depth_s)
    );

    // Fault check in priority order: illegal, underflow, overflow, divide by zero.
    always_comb begin
        fault_s       = 1'b0;
        fault_code_s  = ERR_UNDERFLOW;
        depth_after_s = {1'b0, depth_s} + DW1'(info_s.pushes) - DW1'(info_s.pops);
        if (!info_s.legal) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_ILLEGAL;
        end else if (depth_s < DW'(info_s.pops)) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_UNDERFLOW;
        end else if (depth_after_s > DW1'(STACK_DEPTH)) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_OVERFLOW;
        end else if ((opc_s == OP_DIV || opc_s == OP_MOD) && tos_s == '0) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_DIV_ZERO;
        end else begin
            fault_s      = 1'b0;
            fault_code_s = ERR_UNDERFLOW;
        end
    end

    // Datapath: NOS op TOS; division by -1 is negation so MIN/-1 wraps to MIN.
    always_comb begin
        alu_s = '0;
        case (opc_s)
            OP_ADD:    alu_s = nos_s + tos_s;
            OP_SUB:    alu_s = nos_s - tos_s;
            OP_MUL:    alu_s = nos_s * tos_s;
            OP_DIV: begin
                if (tos_s == '0)                        alu_s = '0;
                else if (tos_s == {DATA_WIDTH{1'b1}})   alu_s = '0 - nos_s;
                else                                    alu_s = nos_s / tos_s;
            end
            OP_MOD: begin
                if (tos_s == '0 || tos_s == {DATA_WIDTH{1'b1}}) alu_s = '0;
                else                                            alu_s = nos_s % tos_s;
            end
            OP_AND:    alu_s = nos_s & tos_s;
            OP_OR:     alu_s = nos_s | tos_s;
            OP_INVERT: alu_s = ~tos_s;
            OP_PUSHI:  alu_s = imm_ext_s;
            default:   alu_s = tos_s;
        endcase
        push_lo_s = alu_s;
        push_hi_s = alu_s;
        if (opc_s == OP_DUP) begin
            push_lo_s = tos_s;
            push_hi_s = tos_s;
        end else if (opc_s == OP_SWAP) begin
            push_lo_s = tos_s;
            push_hi_s = nos_s;
        end else begin
            push_lo_s = alu_s;
            push_hi_s = alu_s;
        end
        new_tos_s = (info_s.pushes == 2'd2) ? push_hi_s : push_lo_s;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_FETCH;
        else       state_r <= next_state_s;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        wb_s         = 1'b0;
        case (state_r)
            ST_FETCH:  next_state_s = ST_DECODE;
            ST_DECODE: begin
                if (fault_s)                next_state_s = ST_ERROR;
                else if (opc_s == OP_HALT)  next_state_s = ST_HALTED;
                else                        next_state_s = ST_EXEC;
            end
            ST_EXEC:   next_state_s = ST_WB;
            ST_WB: begin
                wb_s         = 1'b1;
                next_state_s = (SSTEP_ENABLE != 0) ? ST_PAUSE : ST_FETCH;
            end
            ST_PAUSE: begin
                if (step_edge_s) next_state_s = ST_FETCH;
                else             next_state_s = ST_PAUSE;
            end
            ST_HALTED: next_state_s = ST_HALTED;
            ST_ERROR:  next_state_s = ST_ERROR;
            default:   next_state_s = ST_FETCH;
        endcase
    end

    // Architectural registers; result/valid_result are presented during WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r        <= '0;
            pc_r        <= '0;
            result_r    <= '0;
            push_lo_r   <= '0;
            push_hi_r   <= '0;
            valid_r     <= 1'b0;
            error_r     <= 1'b0;
            halt_r      <= 1'b0;
            err_code_r  <= ERR_UNDERFLOW;
            step_prev_r <= 1'b0;
        end else begin
            step_prev_r <= single_step;
            valid_r     <= 1'b0;
            case (state_r)
                ST_FETCH:  ir_r <= bus.instruction;
                ST_DECODE: begin
                    if (fault_s) begin
                        error_r    <= 1'b1;
                        halt_r     <= 1'b1;
                        err_code_r <= fault_code_s;
                    end else if (opc_s == OP_HALT) begin
                        halt_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    push_lo_r <= push_lo_s;
                    push_hi_r <= push_hi_s;
                    if (info_s.pushes != 2'd0) begin
                        result_r <= new_tos_s;
                        valid_r  <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (opc_s == OP_JMP || (opc_s == OP_JZ && tos_s == '0)) begin
                        pc_r <= imm_s[PC_WIDTH-1:0];
                    end else begin
                        pc_r <= pc_r + PC_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc       = pc_r;
    assign result       = result_r;
    assign valid_result = valid_r;
    assign depth        = depth_s;
    assign error        = error_r;
    assign err_code     = err_code_r;
    assign halt         = halt_r;

endmodule

// File: tb/tb_stack_cpu_ext.sv
// Directed bench: expected pushes go into a scoreboard queue that a monitor
// drains on every valid_result pulse; end-state checks are made inline.
module tb_stack_cpu_ext;
    import stack_cpu_ext_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset0 = 1'b1, reset1 = 1'b1, ss0 = 1'b0, ss1 = 1'b0;
    logic signed [15:0] result0, result1;
    logic               valid0, valid1, error0, error1, halt0, halt1;
    logic [4:0]         depth0, depth1;
    logic [1:0]         ec0, ec1;
    logic [15:0]        prog0 [0:1023];
    logic [15:0]        prog1 [0:1023];

    stack_cpu_ext_if #(.PC_WIDTH(10), .INSTR_WIDTH(16)) bus0 ();
    stack_cpu_ext_if #(.PC_WIDTH(10), .INSTR_WIDTH(16)) bus1 ();
    assign bus0.instruction = prog0[bus0.pc];
    assign bus1.instruction = prog1[bus1.pc];

    stack_cpu_ext #(.SSTEP_ENABLE(0)) dut0 (
        .clk(clk), .reset(reset0), .bus(bus0), .single_step(ss0),
        .result(result0), .valid_result(valid0), .depth(depth0),
        .error(error0), .err_code(ec0), .halt(halt0)
    );

    stack_cpu_ext #(.SSTEP_ENABLE(1)) dut1 (
        .clk(clk), .reset(reset1), .bus(bus1), .single_step(ss1),
        .result(result1), .valid_result(valid1), .depth(depth1),
        .error(error1), .err_code(ec1), .halt(halt1)
    );

    int                 checks = 0;
    int                 errors = 0;
    logic signed [15:0] exp_q [$];
    logic signed [15:0] sb_exp;

    function automatic logic [15:0] ins(input logic [4:0] op, input int imm);
        logic [9:0] i10;
        i10 = 10'(imm);
        return {op, 1'b0, i10};
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int v);
        exp_q.push_back(16'(v));
    endtask

    // Scoreboard monitor for dut0.
    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: valid_result with result %0d, none expected", result0);
            end else begin
                sb_exp = exp_q.pop_front();
                if (result0 !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: got %0d, expected %0d", result0, sb_exp);
                end
            end
        end
    end

    task automatic begin_test0();
        reset0 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) prog0[i] = ins(OP_HALT, 0);
        exp_q.delete();
    endtask

    task automatic release0();
        @(negedge clk);
        reset0 = 1'b0;
    endtask

    task automatic wait_halt0(input string name, input int budget);
        int n = 0;
        while (halt0 !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_halt"}, 32'(halt0), 1);
        chk({name, "_sb_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_pc0(input string name, input int target, input int budget);
        int n = 0;
        while (int'(bus0.pc) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus0.pc), target);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) prog1[i] = ins(OP_HALT, 0);

        // Reset state
        begin_test0();
        chk("rst_pc", 32'(bus0.pc), 0);
        chk("rst_depth", 32'(depth0), 0);
        chk("rst_result", result0, 0);
        chk("rst_flags", {valid0, error0, halt0, ec0}, 0);

        // 7 * -3 with single_step toggling ignored when stepping is disabled
        begin_test0();
        prog0[0] = ins(OP_PUSHI, 7);
        prog0[1] = ins(OP_PUSHI, -3);
        prog0[2] = ins(OP_MUL, 0);
        push_exp(7); push_exp(-3); push_exp(-21);
        ss0 = 1'b1;
        release0();
        repeat (6) @(negedge clk);
        ss0 = 1'b0;
        wait_halt0("mul", 100);
        chk("mul_result", result0, -21);
        chk("mul_depth", 32'(depth0), 1);
        chk("mul_pc", 32'(bus0.pc), 3);
        chk("mul_error", 32'(error0), 0);

        // Divide by zero
        begin_test0();
        prog0[0] = ins(OP_PUSHI, 5);
        prog0[1] = ins(OP_PUSHI, 0);
        prog0[2] = ins(OP_DIV, 0);
        push_exp(5); push_exp(0);
        release0();
        wait_halt0("div0", 100);
        chk("div0_error", 32'(error0), 1);
        chk("div0_code", 32'(ec0), 2);
        chk("div0_pc", 32'(bus0.pc), 2);
        chk("div0_depth", 32'(depth0), 2);

        // SWAP then DROP (DROP must not pulse valid_result)
        begin_test0();
        prog0[0] = ins(OP_PUSHI, 1);
        prog0[1] = ins(OP_PUSHI, 2);
        prog0[2] = ins(OP_SWAP, 0);
        prog0[3] = ins(OP_DROP, 0);
        push_exp(1); push_exp(2); push_exp(1);
        release0();
        wait_halt0("swap", 100);
        chk("swap_result", result0, 1);
        chk("drop_depth", 32'(depth0), 1);
        chk("swap_pc", 32'(bus0.pc), 4);

        // Signed ALU chain
        begin_test0();
        prog0[0]  = ins(OP_PUSHI, -7);  prog0[1]  = ins(OP_PUSHI, 2);
        prog0[2]  = ins(OP_DIV, 0);     prog0[3]  = ins(OP_PUSHI, -7);
        prog0[4]  = ins(OP_PUSHI, 2);   prog0[5]  = ins(OP_MOD, 0);
        prog0[6]  = ins(OP_SUB, 0);     prog0[7]  = ins(OP_DUP, 0);
        prog0[8]  = ins(OP_ADD, 0);     prog0[9]  = ins(OP_INVERT, 0);
        prog0[10] = ins(OP_PUSHI, 6);   prog0[11] = ins(OP_AND, 0);
        prog0[12] = ins(OP_PUSHI, 8);   prog0[13] = ins(OP_OR, 0);
        push_exp(-7); push_exp(2); push_exp(-3); push_exp(-7); push_exp(2);
        push_exp(-1); push_exp(-2); push_exp(-2); push_exp(-4); push_exp(3);
        push_exp(6);  push_exp(2);  push_exp(8);  push_exp(10);
        release0();
        wait_halt0("alu", 200);
        chk("alu_result", result0, 10);
        chk("alu_depth", 32'(depth0), 1);
        chk("alu_pc", 32'(bus0.pc), 14);

        // Most-negative / -1 and MOD sign
        begin_test0();
        prog0[0] = ins(OP_PUSHI, -512); prog0[1] = ins(OP_PUSHI, 64);
        prog0[2] = ins(OP_MUL, 0);      prog0[3] = ins(OP_PUSHI, -1);
        prog0[4] = ins(OP_DIV, 0);      prog0[5] = ins(OP_PUSHI, 7);
        prog0[6] = ins(OP_MOD, 0);      prog0[7] = ins(OP_NOP, 0);
        push_exp(-512); push_exp(64); push_exp(-32768); push_exp(-1);
        push_exp(-32768); push_exp(7); push_exp(-1);
        release0();
        wait_halt0("minneg", 200);
        chk("minneg_result", result0, -1);
        chk("minneg_depth", 32'(depth0), 1);
        chk("minneg_pc", 32'(bus0.pc), 8);

        // JZ taken, JZ not taken, JMP
        begin_test0();
        prog0[0]     = ins(OP_PUSHI, 0);
        prog0[1]     = ins(OP_JZ, 10'h040);
        prog0[10'h40] = ins(OP_PUSHI, 1);
        prog0[10'h41] = ins(OP_JZ, 10'h040);
        prog0[10'h42] = ins(OP_JMP, 10'h100);
        push_exp(0); push_exp(1);
        release0();
        wait_pc0("jz_taken_pc", 32'h40, 40);
        wait_pc0("jz_not_taken_pc", 32'h42, 40);
        wait_halt0("jmp", 60);
        chk("jmp_pc", 32'(bus0.pc), 32'h100);
        chk("jz_depth", 32'(depth0), 0);

        // Overflow on the 17th push
        begin_test0();
        for (int k = 0; k < 17; k++) prog0[k] = ins(OP_PUSHI, k + 1);
        for (int k = 0; k < 16; k++) push_exp(k + 1);
        release0();
        wait_halt0("ovf", 200);
        chk("ovf_error", 32'(error0), 1);
        chk("ovf_code", 32'(ec0), 1);
        chk("ovf_pc", 32'(bus0.pc), 16);
        chk("ovf_depth", 32'(depth0), 16);

        // ADD on empty stack
        begin_test0();
        prog0[0] = ins(OP_ADD, 0);
        release0();
        wait_halt0("udf", 50);
        chk("udf_code", 32'(ec0), 0);
        chk("udf_error", 32'(error0), 1);
        chk("udf_pc", 32'(bus0.pc), 0);

        // Underflow outranks divide-by-zero
        begin_test0();
        prog0[0] = ins(OP_PUSHI, 0);
        prog0[1] = ins(OP_DIV, 0);
        push_exp(0);
        release0();
        wait_halt0("prio", 50);
        chk("prio_code", 32'(ec0), 0);
        chk("prio_pc", 32'(bus0.pc), 1);
        chk("prio_depth", 32'(depth0), 1);

        // Illegal opcode
        begin_test0();
        prog0[0] = ins(OP_PUSHI, 3);
        prog0[1] = ins(5'd20, 0);
        push_exp(3);
        release0();
        wait_halt0("ill", 50);
        chk("ill_code", 32'(ec0), 3);
        chk("ill_pc", 32'(bus0.pc), 1);
        chk("ill_depth", 32'(depth0), 1);

        // Asynchronous reset during EXEC of the third instruction
        begin_test0();
        prog0[0] = ins(OP_PUSHI, 7);
        prog0[1] = ins(OP_PUSHI, -3);
        prog0[2] = ins(OP_MUL, 0);
        push_exp(7); push_exp(-3);
        release0();
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_pc", 32'(bus0.pc), 2);
        chk("pre_rst_depth", 32'(depth0), 2);
        chk("pre_rst_result", result0, -3);
        reset0 = 1'b1;
        #1;
        chk("mid_rst_pc", 32'(bus0.pc), 0);
        chk("mid_rst_depth", 32'(depth0), 0);
        chk("mid_rst_result", result0, 0);
        chk("mid_rst_flags", {valid0, error0, halt0, ec0}, 0);
        chk("mid_rst_sb_drained", exp_q.size(), 0);

        // Single-step CPU: PAUSE after each instruction until a 0->1 edge
        prog1[0] = ins(OP_PUSHI, 4);
        prog1[1] = ins(OP_PUSHI, 5);
        prog1[2] = ins(OP_ADD, 0);
        @(negedge clk);
        reset1 = 1'b0;
        repeat (24) @(negedge clk);
        chk("ss_pause_pc", 32'(bus1.pc), 1);
        chk("ss_pause_depth", 32'(depth1), 1);
        chk("ss_pause_halt", 32'(halt1), 0);
        ss1 = 1'b1;
        repeat (24) @(negedge clk);
        chk("ss_held_pc", 32'(bus1.pc), 2);
        chk("ss_held_depth", 32'(depth1), 2);
        ss1 = 1'b0;
        @(negedge clk);
        ss1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("ss_add_pc", 32'(bus1.pc), 3);
        chk("ss_add_result", result1, 9);
        chk("ss_add_depth", 32'(depth1), 1);
        ss1 = 1'b0;
        @(negedge clk);
        ss1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("ss_halt", 32'(halt1), 1);
        chk("ss_halt_flags", {error1, valid1}, 0);
        chk("ss_halt_pc", 32'(bus1.pc), 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
